// File: rtl/riscv_br_pkg.sv
// Shared definitions for the branch resolution controller: condition codes,
// controller state encoding and the default datapath width.
package riscv_br_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    localparam logic [2:0] COND_BEQ  = 3'b000;
    localparam logic [2:0] COND_BNE  = 3'b001;
    localparam logic [2:0] COND_SLT  = 3'b010;
    localparam logic [2:0] COND_SLTU = 3'b011;
    localparam logic [2:0] COND_BLT  = 3'b100;
    localparam logic [2:0] COND_BGE  = 3'b101;
    localparam logic [2:0] COND_BLTU = 3'b110;
    localparam logic [2:0] COND_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_e;

    // SLT/SLTU encodings are not valid branch conditions
    function automatic logic cond_reserved(input logic [2:0] cond);
        return (cond == COND_SLT) || (cond == COND_SLTU);
    endfunction

endpackage

// File: rtl/br_target_calc.sv
// Combinational target generation: pc+imm for branches/JAL, (rs1+imm)&~1 for
// JALR, the pc+4 fall-through and the taken-target misalignment flag.
module br_target_calc
    import riscv_br_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            jalr,
    output logic [XLEN-1:0] target_c,
    output logic [XLEN-1:0] fallthrough_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum      = rs1 + imm;
        target_c      = jalr ? (jalr_sum & ~XLEN'(1)) : (pc + imm);
        fallthrough_c = pc + XLEN'(4);
        misaligned_c  = target_c[1];
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves conditional branches, JAL and JALR using the shared EX comparator,
// issues redirect + flush on mispredict and keeps saturating statistics.
module branch_resolve_ctrl
    import riscv_br_pkg::*;
#(
    parameter int unsigned XLEN         = DEFAULT_XLEN,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_rs1,
    input  logic [XLEN-1:0]  id_rs2,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic [2:0]       id_cond,
    input  logic             id_pred_taken,
    output logic [XLEN-1:0]  cmp_rs1,
    output logic [XLEN-1:0]  cmp_rs2,
    output logic             cmp_branch,
    output logic [2:0]       cmp_condition,
    input  logic             cmp_result,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    br_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic             jal_q, jal_d, jalr_q, jalr_d, pred_q, pred_d;
    logic [2:0]       cond_q, cond_d;
    logic             cmp_branch_q, cmp_branch_d;
    logic             id_ready_q, id_ready_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             link_valid_q, link_valid_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic             misalign_q, misalign_d;
    logic             illegal_br_q, illegal_br_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [XLEN-1:0]  target_c, fallthrough_c;
    logic             misaligned_c;
    logic             is_jump_c, reserved_c, taken_c;

    br_target_calc #(.XLEN(XLEN)) u_target (
        .pc            (pc_q),
        .imm           (imm_q),
        .rs1           (rs1_q),
        .jalr          (jalr_q),
        .target_c      (target_c),
        .fallthrough_c (fallthrough_c),
        .misaligned_c  (misaligned_c)
    );

    // Next-state, datapath latching and registered outcome pulses
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        imm_d            = imm_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        jal_d            = jal_q;
        jalr_d           = jalr_q;
        cond_d           = cond_q;
        pred_d           = pred_q;
        cmp_branch_d     = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        link_valid_d     = 1'b0;
        link_data_d      = link_data_q;
        misalign_d       = 1'b0;
        illegal_br_d     = 1'b0;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        flush_cnt_d      = flush_cnt_q;

        is_jump_c  = jal_q | jalr_q;
        reserved_c = !is_jump_c && cond_reserved(cond_q);
        taken_c    = is_jump_c || (!reserved_c && cmp_result);

        case (state_q)
            ST_IDLE: begin
                if (id_valid) begin
                    pc_d         = id_pc;
                    imm_d        = id_imm;
                    rs1_d        = id_rs1;
                    rs2_d        = id_rs2;
                    jal_d        = id_jal;
                    jalr_d       = id_jalr;
                    cond_d       = id_cond;
                    pred_d       = id_pred_taken;
                    cmp_branch_d = 1'b1;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                link_valid_d = is_jump_c;
                link_data_d  = fallthrough_c;
                illegal_br_d = reserved_c;
                br_count_d   = (&br_count_q) ? br_count_q : br_count_q + CNT_W'(1);
                if (taken_c && misaligned_c) begin
                    misalign_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (jalr_q || (taken_c != pred_q)) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = taken_c ? target_c : fallthrough_c;
                    mispred_count_d  = (&mispred_count_q) ? mispred_count_q
                                                          : mispred_count_q + CNT_W'(1);
                    state_d          = ST_REDIRECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                flush_cnt_d = FC_W'(FLUSH_CYCLES);
                state_d     = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FC_W'(1);
                if ((flush_cnt_q == FC_W'(1)) || (flush_cnt_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and flush follow the state being entered so they stay registered
        id_ready_d = (state_d == ST_IDLE);
        flush_d    = (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            pc_q             <= '0;
            imm_q            <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            jal_q            <= 1'b0;
            jalr_q           <= 1'b0;
            cond_q           <= '0;
            pred_q           <= 1'b0;
            cmp_branch_q     <= 1'b0;
            id_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            link_valid_q     <= 1'b0;
            link_data_q      <= '0;
            misalign_q       <= 1'b0;
            illegal_br_q     <= 1'b0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
            flush_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            imm_q            <= imm_d;
            rs1_q            <= rs1_d;
            rs2_q            <= rs2_d;
            jal_q            <= jal_d;
            jalr_q           <= jalr_d;
            cond_q           <= cond_d;
            pred_q           <= pred_d;
            cmp_branch_q     <= cmp_branch_d;
            id_ready_q       <= id_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            link_valid_q     <= link_valid_d;
            link_data_q      <= link_data_d;
            misalign_q       <= misalign_d;
            illegal_br_q     <= illegal_br_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign id_ready       = id_ready_q;
    assign cmp_rs1        = rs1_q;
    assign cmp_rs2        = rs2_q;
    assign cmp_branch     = cmp_branch_q;
    assign cmp_condition  = cond_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign misalign       = misalign_q;
    assign illegal_br     = illegal_br_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: transaction-level schedule model checked every
// cycle on two instances (32-bit and 2-bit counters) plus directed literal checks.
module tb_branch_resolve_ctrl;
    import riscv_br_pkg::*;

    localparam int FC   = 2;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_imm = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_jal = 1'b0, id_jalr = 1'b0, id_pred_taken = 1'b0;
    logic [2:0]  id_cond = '0;

    logic        id_ready, cmp_branch, cmp_result, redirect_valid, flush;
    logic        link_valid, misalign, illegal_br;
    logic [31:0] cmp_rs1, cmp_rs2, redirect_pc, link_data, br_count, mispred_count;
    logic [2:0]  cmp_condition;

    logic        id_ready2, cmp_branch2, cmp_result2, redirect_valid2, flush2;
    logic        link_valid2, misalign2, illegal_br2;
    logic [31:0] cmp_rs1_2, cmp_rs2_2, redirect_pc2, link_data2;
    logic [1:0]  br_count2, mispred_count2;
    logic [2:0]  cmp_condition2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int free_at = 1 << 30;
    int m_br = 0, m_mp = 0;

    bit          exp_ready[MAXC], exp_flush[MAXC], exp_redir[MAXC], exp_link[MAXC];
    bit          exp_mis[MAXC], exp_ill[MAXC], exp_cmpb[MAXC], exp_rst[MAXC];
    logic [31:0] exp_rpc[MAXC], exp_ld[MAXC], exp_c1[MAXC], exp_c2[MAXC];
    logic [2:0]  exp_cc[MAXC];
    int          exp_brc[MAXC], exp_mpc[MAXC];

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_cond(id_cond),
        .id_pred_taken(id_pred_taken), .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2),
        .cmp_branch(cmp_branch), .cmp_condition(cmp_condition),
        .cmp_result(cmp_result), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .link_valid(link_valid),
        .link_data(link_data), .misalign(misalign), .illegal_br(illegal_br),
        .br_count(br_count), .mispred_count(mispred_count));

    branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready2),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_cond(id_cond),
        .id_pred_taken(id_pred_taken), .cmp_rs1(cmp_rs1_2), .cmp_rs2(cmp_rs2_2),
        .cmp_branch(cmp_branch2), .cmp_condition(cmp_condition2),
        .cmp_result(cmp_result2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .flush(flush2), .link_valid(link_valid2),
        .link_data(link_data2), .misalign(misalign2), .illegal_br(illegal_br2),
        .br_count(br_count2), .mispred_count(mispred_count2));

    // Reference comparator (the EX-stage unit): SLT/SLTU codes give set-less-than
    function automatic logic cond_true(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            COND_BEQ:  return a == b;
            COND_BNE:  return a != b;
            COND_SLT:  return $signed(a) < $signed(b);
            COND_SLTU: return a < b;
            COND_BLT:  return $signed(a) < $signed(b);
            COND_BGE:  return $signed(a) >= $signed(b);
            COND_BLTU: return a < b;
            default:   return a >= b;
        endcase
    endfunction

    always_comb cmp_result  = cmp_branch  && cond_true(cmp_condition,  cmp_rs1,   cmp_rs2);
    always_comb cmp_result2 = cmp_branch2 && cond_true(cmp_condition2, cmp_rs1_2, cmp_rs2_2);

    function automatic int sat(input int v, input int w);
        int mx;
        if (w >= 31) return v;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Spec-level resolution of one accepted op, scheduled onto future cycles
    task automatic model_accept(input int e);
        logic [31:0] tgt, ft, rpc;
        logic        jump, resv, taken, mis, redir;
        jump  = id_jal | id_jalr;
        resv  = !jump && (id_cond == COND_SLT || id_cond == COND_SLTU);
        taken = jump ? 1'b1 : (resv ? 1'b0 : cond_true(id_cond, id_rs1, id_rs2));
        tgt   = id_jalr ? ((id_rs1 + id_imm) & 32'hFFFF_FFFE) : (id_pc + id_imm);
        ft    = id_pc + 32'd4;
        mis   = taken && tgt[1];
        redir = !mis && (id_jalr || (taken != id_pred_taken));
        rpc   = taken ? tgt : ft;
        exp_ready[e] = 1'b0;
        exp_cmpb[e]  = 1'b1;
        exp_c1[e] = id_rs1; exp_c2[e] = id_rs2; exp_cc[e] = id_cond;
        exp_link[e+1] = jump; exp_ld[e+1] = ft;
        exp_mis[e+1]  = mis;
        exp_ill[e+1]  = resv;
        m_br++;
        for (int j = e + 1; j < MAXC; j++) exp_brc[j] = m_br;
        if (redir) begin
            m_mp++;
            for (int j = e + 1; j < MAXC; j++) exp_mpc[j] = m_mp;
            exp_redir[e+1] = 1'b1; exp_rpc[e+1] = rpc;
            for (int j = e + 1; j <= e + 1 + FC; j++) begin
                exp_ready[j] = 1'b0;
                exp_flush[j] = 1'b1;
            end
            free_at = e + 3 + FC;
        end else begin
            free_at = e + 2;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC - 8) begin
            if (rst) begin
                chk_en = 1'b1;
                m_br = 0; m_mp = 0;
                free_at = cyc + 1;
                for (int j = cyc; j < MAXC; j++) begin
                    exp_ready[j] = 1'b1; exp_flush[j] = 1'b0; exp_redir[j] = 1'b0;
                    exp_link[j] = 1'b0; exp_mis[j] = 1'b0; exp_ill[j] = 1'b0;
                    exp_cmpb[j] = 1'b0; exp_rst[j] = 1'b0;
                    exp_brc[j] = 0; exp_mpc[j] = 0;
                end
                exp_rst[cyc] = 1'b1;
            end else if (id_valid && cyc >= free_at) begin
                model_accept(cyc);
            end
        end
    end

    task automatic check_dut(input string t, input int k, input int w,
        input logic rdy, input logic fl, input logic rv, input logic [31:0] rpc,
        input logic lv, input logic [31:0] ld, input logic ms, input logic il,
        input logic cb, input logic [31:0] c1, input logic [31:0] c2, input logic [2:0] cc,
        input logic [31:0] bc, input logic [31:0] mc);
        chk({t, "_id_ready"},       32'(rdy), 32'(exp_ready[k]));
        chk({t, "_flush"},          32'(fl),  32'(exp_flush[k]));
        chk({t, "_redirect_valid"}, 32'(rv),  32'(exp_redir[k]));
        chk({t, "_link_valid"},     32'(lv),  32'(exp_link[k]));
        chk({t, "_misalign"},       32'(ms),  32'(exp_mis[k]));
        chk({t, "_illegal_br"},     32'(il),  32'(exp_ill[k]));
        chk({t, "_cmp_branch"},     32'(cb),  32'(exp_cmpb[k]));
        chk({t, "_br_count"},       bc, 32'(sat(exp_brc[k], w)));
        chk({t, "_mispred_count"},  mc, 32'(sat(exp_mpc[k], w)));
        if (exp_redir[k]) chk({t, "_redirect_pc"}, rpc, exp_rpc[k]);
        if (exp_link[k])  chk({t, "_link_data"}, ld, exp_ld[k]);
        if (exp_cmpb[k]) begin
            chk({t, "_cmp_rs1"}, c1, exp_c1[k]);
            chk({t, "_cmp_rs2"}, c2, exp_c2[k]);
            chk({t, "_cmp_condition"}, 32'(cc), 32'(exp_cc[k]));
        end
        if (exp_rst[k]) begin
            chk({t, "_rst_redirect_pc"}, rpc, 32'd0);
            chk({t, "_rst_link_data"}, ld, 32'd0);
            chk({t, "_rst_cmp_ops"}, c1 | c2 | 32'(cc), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC - 8) begin
            check_dut("w32", cyc, 32, id_ready, flush, redirect_valid, redirect_pc,
                      link_valid, link_data, misalign, illegal_br, cmp_branch,
                      cmp_rs1, cmp_rs2, cmp_condition, br_count, mispred_count);
            check_dut("w2", cyc, 2, id_ready2, flush2, redirect_valid2, redirect_pc2,
                      link_valid2, link_data2, misalign2, illegal_br2, cmp_branch2,
                      cmp_rs1_2, cmp_rs2_2, cmp_condition2, 32'(br_count2), 32'(mispred_count2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic jal, input logic jalr,
                         input logic [2:0] cond, input logic pred, output int acc);
        logic rdy;
        id_pc = pc; id_imm = imm; id_rs1 = rs1; id_rs2 = rs2;
        id_jal = jal; id_jalr = jalr; id_cond = cond; id_pred_taken = pred;
        id_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            rdy = id_ready;
            step();
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        id_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, nfl;
        step();
        step();
        rst = 1'b0;
        chk("reset_id_ready", 32'(id_ready), 32'd1);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_br_count", br_count, 32'd0);

        // BEQ taken, predicted not-taken: redirect to 0x120 with 3-cycle flush
        issue(32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, COND_BEQ, 1'b0, acc);
        step();
        chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_mispred_count", mispred_count, 32'd1);
        nfl = 0;
        for (int i = 0; i < 8; i++) begin
            if (flush) nfl++;
            step();
        end
        chk("beq_flush_len", 32'(nfl), 32'd3);

        // BLT signed -1 < 1, correctly predicted taken
        do_reset();
        issue(32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, COND_BLT, 1'b1, acc);
        chk("blt_busy_in_eval", 32'(id_ready), 32'd0);
        step();
        chk("blt_ready_back", 32'(id_ready), 32'd1);
        chk("blt_br_count", br_count, 32'd1);
        chk("blt_mispred_count", mispred_count, 32'd0);
        chk("blt_no_redirect", 32'(redirect_valid), 32'd0);

        // JALR always redirects; bit0 of the target is cleared
        issue(32'h40, 32'h0, 32'h1001, 32'h0, 1'b0, 1'b1, COND_BEQ, 1'b0, acc);
        step();
        chk("jalr_link_valid", 32'(link_valid), 32'd1);
        chk("jalr_link_data", link_data, 32'h44);
        chk("jalr_redirect_pc", redirect_pc, 32'h1000);
        // Target bit1 set: misalign pulse, no redirect
        issue(32'h40, 32'h0, 32'h1002, 32'h0, 1'b0, 1'b1, COND_BEQ, 1'b0, acc);
        step();
        chk("jalr_misalign", 32'(misalign), 32'd1);
        chk("jalr_mis_no_redirect", 32'(redirect_valid), 32'd0);
        issue(32'h40, 32'h0, 32'h1003, 32'h0, 1'b0, 1'b1, COND_BEQ, 1'b1, acc);
        issue(32'h300, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, COND_BEQ, 1'b1, acc);
        step();
        chk("jal_pred_ok_no_redirect", 32'(redirect_valid), 32'd0);
        chk("jal_link_data", link_data, 32'h304);

        // Reserved condition with rs1<rs2: forced not-taken, illegal pulse
        issue(32'h500, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0, COND_SLT, 1'b1, acc);
        step();
        chk("slt_illegal_br", 32'(illegal_br), 32'd1);
        chk("slt_redirect_pc", redirect_pc, 32'h504);

        // id_valid held through REDIRECT/FLUSH: next op waits for IDLE
        issue(32'h600, 32'h8, 32'd3, 32'd3, 1'b0, 1'b0, COND_BNE, 1'b1, acc);
        issue(32'h700, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0, COND_BLTU, 1'b1, acc2);
        chk("hold_accept_gap", 32'(acc2 - acc), 32'd5);
        step();

        // Reset while in REDIRECT aborts the op
        issue(32'h800, 32'h10, 32'd1, 32'd1, 1'b0, 1'b0, COND_BEQ, 1'b0, acc);
        step();
        chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_id_ready", 32'(id_ready), 32'd1);
        chk("rst_mid_mispred", mispred_count, 32'd0);
        chk("rst_mid_redirect_pc", redirect_pc, 32'd0);
        step();

        // Five correctly-predicted branches: 2-bit counter saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++)
            issue(32'h900, 32'h10, 32'd1, 32'd2, 1'b0, 1'b0, COND_BGEU, 1'b0, acc);
        step();
        chk("sat_br_count_w2", 32'(br_count2), 32'd3);
        chk("sat_br_count_w32", br_count, 32'd5);

        // JAL and JALR both set: behaves as JALR
        issue(32'h10, 32'h4, 32'h2000, 32'h0, 1'b1, 1'b1, COND_BEQ, 1'b1, acc);
        step();
        chk("both_as_jalr_pc", redirect_pc, 32'h2004);
        chk("both_link_data", link_data, 32'h14);

        // Model-only mix: signed/unsigned conditions, mispredicted not-taken
        issue(32'hA00, 32'hFFFF_FFF0, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 1'b0, 1'b0, COND_BGE, 1'b0, acc);
        issue(32'hB00, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, COND_BLTU, 1'b1, acc);
        issue(32'hC00, 32'h22, 32'd7, 32'd7, 1'b0, 1'b0, COND_BEQ, 1'b0, acc);
        issue(32'hD00, 32'h8, 32'd1, 32'd0, 1'b0, 1'b0, COND_SLTU, 1'b0, acc);
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
